// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect
// Brief    : Fetch-side PC sequencer. Detects taken conditional branches
//            from the ID-resolved next-PC, redirects fetch, squashes the
//            wrong-path IF/ID slot, buffers redirects seen during stalls,
//            handles halt and counts taken branches.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          STEP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [15:0] br_next,
  input  logic [15:0] id_pc,
  input  logic        halt_req,
  output logic [15:0] imem_addr,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic [15:0] taken_cnt,
  output logic        err_misalign,
  output logic        halted
);

  localparam logic [1:0]  c_run    = 2'd0;
  localparam logic [1:0]  c_bubble = 2'd1;
  localparam logic [1:0]  c_halt   = 2'd2;
  localparam logic [15:0] c_step   = 16'(STEP);
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_pc;
  logic        r_pend_valid;
  logic [15:0] r_pend_target;
  logic [15:0] r_taken_cnt;
  logic        r_err;

  logic [15:0] w_fallthru;
  logic        w_taken;
  logic [15:0] w_tgt;
  logic        w_in_run;
  logic        w_accept;
  logic        w_redirect;
  logic [15:0] w_redirect_pc;

  // A branch is taken when its resolved next-PC differs from its own fall-through (16-bit wrap).
  assign w_fallthru    = id_pc + c_step;
  assign w_taken       = br_valid & (br_next != w_fallthru);
  assign w_tgt         = {br_next[15:1], 1'b0};
  assign w_in_run      = (r_state == c_run);
  // Only RUN looks at br_valid; halt takes priority over any branch in the same cycle.
  assign w_accept      = w_in_run & ~halt_req & w_taken;
  assign w_redirect    = w_in_run & ~halt_req & ~stall & (w_taken | r_pend_valid);
  // A fresh taken branch wins over an older buffered target.
  assign w_redirect_pc = w_taken ? w_tgt : r_pend_target;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_run;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: redirect costs one bubble cycle, halt is terminal until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_run: begin
        if (halt_req) begin
          w_state_nxt = c_halt;
        end else if (w_redirect) begin
          w_state_nxt = c_bubble;
        end else begin
          w_state_nxt = c_run;
        end
      end
      c_bubble: begin
        w_state_nxt = halt_req ? c_halt : c_run;
      end
      c_halt: begin
        w_state_nxt = c_halt;
      end
      default: begin
        w_state_nxt = c_run;
      end
    endcase
  end

  // Output decode: flush_ifid is the only output that looks at inputs.
  always_comb begin
    if_valid   = 1'b0;
    flush_ifid = 1'b0;
    halted     = 1'b0;
    case (r_state)
      c_run: begin
        if_valid   = 1'b1;
        flush_ifid = halt_req | w_redirect;
      end
      c_bubble: begin
        if_valid = 1'b0;
      end
      c_halt: begin
        halted = 1'b1;
      end
      default: begin
        if_valid = 1'b0;
      end
    endcase
  end

  // PC update: hold on halt/stall, jump on redirect, otherwise step sequentially.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      case (r_state)
        c_run: begin
          if (halt_req || stall) begin
            r_pc <= r_pc;
          end else if (w_redirect) begin
            r_pc <= w_redirect_pc;
          end else begin
            r_pc <= r_pc + c_step;
          end
        end
        c_bubble: begin
          if (!halt_req && !stall) begin
            r_pc <= r_pc + c_step;
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // Pending redirect buffer: filled by taken branches during a stall, drained on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 16'h0000;
    end else if (w_accept && stall) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= w_tgt;
    end else if (w_redirect) begin
      r_pend_valid  <= 1'b0;
    end
  end

  // Saturating taken counter and sticky misalignment flag, both per accepted branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= 16'h0000;
      r_err       <= 1'b0;
    end else begin
      if (w_accept && (r_taken_cnt != c_cnt_max)) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
      if (w_accept && br_next[0]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign taken_cnt    = r_taken_cnt;
  assign err_misalign = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect
// Brief    : Scoreboard bench for fetch_redirect. A cycle-level reference
//            model predicts the outputs of every cycle; a monitor on the
//            falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect;

  localparam logic [15:0] c_reset_pc = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [15:0] br_next;
  logic [15:0] id_pc;
  logic        halt_req;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic        flush_ifid;
  logic [15:0] taken_cnt;
  logic        err_misalign;
  logic        halted;

  fetch_redirect #(.RESET_PC(c_reset_pc), .STEP(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_next      (br_next),
    .id_pc        (id_pc),
    .halt_req     (halt_req),
    .imem_addr    (imem_addr),
    .if_valid     (if_valid),
    .flush_ifid   (flush_ifid),
    .taken_cnt    (taken_cnt),
    .err_misalign (err_misalign),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        ifv;
    logic        flush;
    logic [15:0] cnt;
    logic        err;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, in the terms the block is described with.
  localparam int c_m_run = 0, c_m_bubble = 1, c_m_halt = 2;
  int          m_mode;
  logic [15:0] m_pc;
  bit          m_pend;
  logic [15:0] m_pend_tgt;
  int          m_cnt;
  bit          m_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = c_m_run; m_pc = c_reset_pc; m_pend = 0; m_pend_tgt = 16'h0;
    m_cnt = 0; m_err = 0;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit st, input bit bv, input logic [15:0] bn,
                      input logic [15:0] ip, input bit hr);
    exp_t        e;
    bit          tk;
    logic [15:0] tgt;
    logic [15:0] diff;
    stall = st; br_valid = bv; br_next = bn; id_pc = ip; halt_req = hr;
    diff = bn - ip;
    tk   = bv && (diff != 16'd2);
    tgt  = bn & 16'hFFFE;
    e.addr  = m_pc;
    e.ifv   = (m_mode == c_m_run);
    e.flush = (m_mode == c_m_run) && (hr || (!st && (tk || m_pend)));
    e.cnt   = 16'(m_cnt);
    e.err   = m_err;
    e.hlt   = (m_mode == c_m_halt);
    q.push_back(e);
    if (m_mode == c_m_run) begin
      if (hr) begin
        m_mode = c_m_halt;
      end else begin
        if (tk) begin
          if (m_cnt < 65535) m_cnt++;
          if (bn[0]) m_err = 1;
        end
        if (st) begin
          if (tk) begin m_pend = 1; m_pend_tgt = tgt; end
        end else if (tk || m_pend) begin
          m_pc   = tk ? tgt : m_pend_tgt;
          m_pend = 0;
          m_mode = c_m_bubble;
        end else begin
          m_pc = m_pc + 16'd2;
        end
      end
    end else if (m_mode == c_m_bubble) begin
      if (hr) m_mode = c_m_halt;
      else begin
        if (!st) m_pc = m_pc + 16'd2;
        m_mode = c_m_run;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 0);
  endtask

  // Monitor: every falling edge the DUT presents one cycle of outputs.
  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_addr",    imem_addr,           e.addr);
      chk("if_valid",     {15'd0, if_valid},   {15'd0, e.ifv});
      chk("flush_ifid",   {15'd0, flush_ifid}, {15'd0, e.flush});
      chk("taken_cnt",    taken_cnt,           e.cnt);
      chk("err_misalign", {15'd0, err_misalign}, {15'd0, e.err});
      chk("halted",       {15'd0, halted},     {15'd0, e.hlt});
    end
  end

  initial begin
    logic [15:0] rip;
    logic [15:0] rbn;
    rst = 1'b1; stall = 0; br_valid = 0; br_next = 0; id_pc = 0; halt_req = 0;
    model_reset();
    #2;
    chk("reset_addr",   imem_addr, c_reset_pc);
    chk("reset_ifv",    {15'd0, if_valid}, 16'd1);
    chk("reset_halted", {15'd0, halted}, 16'd0);
    chk("reset_cnt",    taken_cnt, 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch from reset, then up to pc=0010.
    idle(8);
    // Taken branch to 0040.
    step(0, 1, 16'h0040, 16'h000E, 0);
    idle(2);
    // Not-taken branch.
    step(0, 1, 16'h0010, 16'h000E, 0);
    idle(1);
    // Taken branch during a 3-cycle stall, redirect when the stall drops.
    step(1, 1, 16'h0080, 16'h0044, 0);
    step(1, 0, 16'h0000, 16'h0044, 0);
    step(1, 0, 16'h0000, 16'h0044, 0);
    step(0, 0, 16'h0000, 16'h0044, 0);
    idle(2);
    // Overwrite of a pending entry within one stall.
    step(1, 1, 16'h0100, 16'h0084, 0);
    step(1, 1, 16'h0200, 16'h0084, 0);
    step(0, 0, 16'h0000, 16'h0084, 0);
    idle(2);
    // Fall-through wraps: FFFE+2 = 0000 is not taken.
    step(0, 1, 16'h0000, 16'hFFFE, 0);
    // PC wraps while free-running.
    step(0, 1, 16'hFFFC, 16'h0300, 0);
    idle(4);
    // Misaligned target.
    step(0, 1, 16'h0051, 16'h0400, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rip = 16'($urandom) & 16'hFFFE;
      rbn = ($urandom % 2 == 0) ? rip + 16'd2 : 16'($urandom);
      step(($urandom % 5) == 0, ($urandom % 3) == 0, rbn, rip, 0);
    end

    // Halt, then everything ignored.
    step(0, 0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 10; i++) begin
      rip = 16'($urandom) & 16'hFFFE;
      step($urandom % 2 == 1, 1, rip + 16'h0040, rip, $urandom % 2 == 1);
    end

    // Asynchronous reset mid-cycle, checked before any clock edge.
    @(negedge clk); #1;
    stall = 0; br_valid = 0; halt_req = 0;
    rst = 1'b1;
    #1;
    chk("async_addr",   imem_addr, c_reset_pc);
    chk("async_ifv",    {15'd0, if_valid}, 16'd1);
    chk("async_flush",  {15'd0, flush_ifid}, 16'd0);
    chk("async_cnt",    taken_cnt, 16'd0);
    chk("async_err",    {15'd0, err_misalign}, 16'd0);
    chk("async_halted", {15'd0, halted}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(3);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Fetch-side PC sequencer for the 16-bit pipeline. It consumes the resolved next-PC produced in ID for conditional branches (opcodes 0100/0101/0110).
- Maintains the architectural fetch PC. Decides whether a branch was taken by comparing the resolved next-PC against the branch instruction's PC+2.
- On a taken branch it redirects fetch, squashes the wrong-path IF/ID instruction and inserts one fetch bubble.
- Also handles pipeline stalls, buffers a redirect that arrives during a stall, handles halt, and keeps a taken-branch counter.

Parameters:
RESET_PC, 16'h0000, fetch address loaded on reset
STEP, 2, sequential PC increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from ID; PC must hold
br_valid  input  1  ID holds a resolved conditional branch this cycle
br_next  input  16  next-PC resolved by ID (target, or id_pc+2 if not taken)
id_pc  input  16  PC of the instruction currently in ID
halt_req  input  1  ID decoded halt (opcode 1111)
imem_addr  output  16  fetch address (equals PC register)
if_valid  output  1  fetched instruction is valid for IF/ID
flush_ifid  output  1  squash IF/ID contents at next edge
taken_cnt  output  16  taken-branch count, saturating
err_misalign  output  1  sticky flag, a redirect target had bit0=1
halted  output  1  core halted

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=RUN.
  - pend_valid=0, pend_target=0.
  - taken_cnt=0, err_misalign=0.
  - Resulting outputs: imem_addr=RESET_PC, if_valid=1, flush_ifid=0, halted=0.
- taken = br_valid & (br_next != (id_pc+STEP)). The sum is 16-bit and wraps (id_pc=16'hFFFE gives 16'h0000).
- tgt = {br_next[15:1],1'b0}. If br_next[0]=1 on a taken branch, err_misalign sets and stays set until rst.
- States: RUN, BUBBLE, HALT. imem_addr=pc in every state.
- RUN, evaluated in priority order:
  1. halt_req=1 → HALT. pc holds, flush_ifid=1 this cycle.
  2. stall=1 → pc holds, if_valid=1. If taken: pend_valid<=1, pend_target<=tgt. A later taken in the same stall overwrites the pending entry.
  3. taken, or pend_valid=1 → pc<=tgt (pend_target if pend_valid and no new taken), flush_ifid=1 combinational this cycle, pend_valid<=0, → BUBBLE.
  4. Otherwise pc<=pc+STEP (16-bit wrap, 16'hFFFE→16'h0000), if_valid=1.
- taken_cnt increments once per taken branch when the branch is accepted (including when it is buffered during a stall), saturating at 16'hFFFF. An overwrite of a pending entry counts again.
- BUBBLE:
  - Lasts exactly one cycle; if_valid=0, flush_ifid=0.
  - If stall=0: pc<=pc+STEP, → RUN.
  - If stall=1: pc holds, → RUN.
  - br_valid is ignored, because the ID stage holds a squashed bubble.
  - halt_req=1 → HALT.
- HALT:
  - pc frozen, if_valid=0, flush_ifid=0, halted=1.
  - All inputs ignored; the only exit is rst.
- Latency: a taken branch seen in cycle N gives imem_addr=target in cycle N+1 and if_valid=1 in cycle N+2.
- A not-taken branch (br_next==id_pc+STEP) behaves exactly like a non-branch: no flush, no count.
- Outputs are decoded from state and registers only. flush_ifid is the only output that depends combinationally on inputs.

Test Plan:
- Reset + sequential fetch: rst pulse, 4 idle cycles → imem_addr 0000,0002,0004,0006; if_valid=1; taken_cnt=0.
- Taken branch: pc=0010, br_valid=1, id_pc=000E, br_next=0040 → flush_ifid=1 that cycle; next imem_addr=0040 with if_valid=0; following cycle imem_addr=0042, if_valid=1; taken_cnt=1.
- Not-taken branch: id_pc=000E, br_next=0010 → no flush, PC steps normally, taken_cnt unchanged.
- Redirect during stall: stall=1 for 3 cycles with taken br_next=0080 in the first → pc held; when stall drops, flush_ifid=1 and pc→0080, then BUBBLE.
- Boundary cases:
  - id_pc=FFFE, br_next=0000 → not taken (wrap).
  - pc=FFFE, free-running → wraps to 0000.
  - Taken br_next=0051 → pc=0050, err_misalign=1 and stays set.
- Halt and async reset: halt_req=1 → halted=1, if_valid=0, pc frozen for 10 cycles despite br_valid. Assert rst mid-cycle → outputs return to reset values immediately, without a clock edge.
